posit_accum: RTL and testbench
==============================

Name: posit_accum

Overview:
- Sequential streaming accumulator placed around the combinational posit adder.
- Accepts a frame of `len` posit operands over a valid/ready handshake and feeds each one, with the running sum, into an `adder #(N,ES)` instance.
- Registers the adder's `posit` output as the new running sum and presents the final sum on an output valid/ready port.
- Serves as the reduction stage for dot-product and sum datapaths.

Parameters:
- N, 16, posit word width; passed to the adder.
- ES, 3, exponent field width; passed to the adder.
- LEN_W, 8, width of the frame-length field (max frame = 2^LEN_W-1 operands).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle frame request, sampled only in IDLE
- len  input  LEN_W  operand count for the frame, sampled with start
- in_valid  input  1  operand valid
- in_ready  output  1  operand accepted when in_valid && in_ready
- in_data  input  N  operand posit
- out_valid  output  1  final sum valid
- out_ready  input  1  consumer accepts sum
- out_data  output  N  final sum posit
- busy  output  1  high in any state other than IDLE
- nar_seen  output  1  sticky: some operand in the current frame was NaR (1 followed by N-1 zeros)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc=0; remaining=0; nar_seen=0.
  - out_valid=0, in_ready=0, busy=0, out_data=0.
  - Reset mid-frame discards all partial state; no output is produced for that frame.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 and len!=0: acc<=0, remaining<=len, nar_seen<=0, next state ACCUM.
  - start=1 and len=0: acc<=0, nar_seen<=0, next state DONE; the result is zero.
- ACCUM:
  - in_ready=1.
  - On each handshake: acc<=adder(acc,in_data).posit, remaining<=remaining-1, nar_seen<=nar_seen | (in_data==NaR).
  - The handshake that brings remaining from 1 to 0 moves the state to DONE.
  - Throughput: one operand per cycle; the combinational adder path lies between acc/in_data and the acc D-input.
  - Bubbles (in_valid=0) hold all state.
- DONE:
  - out_valid=1, out_data=acc.
  - out_data is stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: next state IDLE; acc is held (not cleared) until the next start.
- Latency: out_valid rises in the cycle after the last operand handshake.
- NaR: once nar_seen=1, out_data is forced to NaR regardless of acc. NaR is absorbing in the adder anyway; this guarantees it independently of the adder.
- Opposite operands: an exact zero in acc is a valid intermediate value; accumulation continues normally.
- start is ignored outside IDLE; len is sampled only in the start cycle.
- busy=(state!=IDLE).
- Rounding is entirely the adder's: acc takes the adder output unmodified, with no extra rounding or saturation stage.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; both readies and valids are decoded from the state register only.

Test Plan:
- Reset then start len=4 with four beats of 0100000000000000 (1.0) -> out_valid one cycle after beat 4, out_data=0100100000000000 (4.0), nar_seen=0.
- start len=2, beats 0100100000000000 (4) and 0101000000000000 (16), with in_valid gapped by 3 idle cycles -> out_data=0101000100000000 (20); acc unchanged during gaps.
- start len=3, beats 0100010000000000 (2), 1100000000000000 (-1), 1000000000000000 (NaR) -> out_data=1000000000000000, nar_seen=1.
- start len=0 -> DONE next cycle, out_data=0; hold out_ready=0 for 5 cycles -> out_valid and out_data stable; start pulses during the hold are ignored.
- start len=2, beats 1100110011111001 and its two's-complement negation -> out_data=0000000000000000.
- Assert rst_n=0 after 2 of 4 beats -> all outputs are reset values immediately; the following frame len=1 with 0100000000000000 returns 0100000000000000.

Source files
------------

// File: rtl/posit_accum.sv
// Streaming posit accumulator: sums a frame of posit operands through a
// combinational posit adder, one operand per cycle, and presents the final
// sum on a valid/ready output port. Also contains the posit adder it wraps.

module adder #(
    parameter int N  = 16,
    parameter int ES = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] posit
);
    // Fraction bits, mantissa width with hidden bit, alignment guard bits
    localparam int FW = N - ES - 3;
    localparam int MW = FW + 1;
    localparam int GB = 14;
    localparam int WW = MW + GB;
    localparam int SW = 12;
    // Encoding scratch width: room for regime, exponent, full fraction, guard
    localparam int T  = ES + WW;
    localparam int L  = N + ES + WW + 1;

    localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ZERO = {N{1'b0}};

    // Split a nonzero, non-NaR posit into sign, scale (k*2^ES + e) and 1.f mantissa
    function automatic void decode(
        input  logic [N-1:0]          p,
        output logic                  sgn,
        output logic signed [SW-1:0]  scl,
        output logic [MW-1:0]         mnt
    );
        logic [N-1:0] mag;
        logic [N-2:0] body;
        logic [N-2:0] sh;
        logic         r0;
        logic         stop;
        int           m;
        int           k;
        int           s;
        sgn  = p[N-1];
        mag  = p[N-1] ? (~p + {{(N-1){1'b0}}, 1'b1}) : p;
        body = mag[N-2:0];
        r0   = body[N-2];
        m    = 0;
        stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (body[i] == r0)) begin
                m = m + 1;
            end else begin
                stop = 1'b1;
            end
        end
        k   = r0 ? (m - 1) : -m;
        // Drop the regime run and its terminator; exponent then fraction follow
        sh  = body << (m + 1);
        s   = k * (2 ** ES) + int'(sh[N-2 -: ES]);
        scl = s[SW-1:0];
        mnt = {1'b1, sh[N-2-ES -: FW]};
    endfunction

    // Full posit addition with round-to-nearest-even and saturation to
    // maxpos/minpos (a nonzero sum never rounds to zero or NaR)
    function automatic logic [N-1:0] add_core(
        input logic [N-1:0] x,
        input logic [N-1:0] y
    );
        logic [N-1:0]         res;
        logic                 xs;
        logic                 ys;
        logic                 bs;
        logic signed [SW-1:0] xscl;
        logic signed [SW-1:0] yscl;
        logic signed [SW-1:0] bscl;
        logic signed [SW-1:0] sscl;
        logic [MW-1:0]        xm;
        logic [MW-1:0]        ym;
        logic [MW-1:0]        bm;
        logic [MW-1:0]        sm;
        logic [WW-1:0]        av;
        logic [WW-1:0]        bf;
        logic [WW-1:0]        bv;
        logic                 st;
        logic [WW:0]          sum;
        logic [WW:0]          nm;
        logic [WW-1:0]        frac;
        logic [ES-1:0]        ev;
        logic [L-1:0]         tail;
        logic [L-1:0]         pat;
        logic [L-1:0]         v;
        logic [N-2:0]         body;
        logic                 g;
        logic                 stk;
        int                   diff;
        int                   p;
        int                   rscl;
        int                   k;
        int                   rl;
        res = ZERO;
        if ((x == NAR) || (y == NAR)) begin
            res = NAR;
        end else if (x == ZERO) begin
            res = y;
        end else if (y == ZERO) begin
            res = x;
        end else begin
            decode(x, xs, xscl, xm);
            decode(y, ys, yscl, ym);
            // Order operands by magnitude so the subtraction never goes negative
            if ((xscl > yscl) || ((xscl == yscl) && (xm >= ym))) begin
                bs = xs; bscl = xscl; bm = xm; sscl = yscl; sm = ym;
            end else begin
                bs = ys; bscl = yscl; bm = ym; sscl = xscl; sm = xm;
            end
            diff = int'(bscl) - int'(sscl);
            av   = {bm, {GB{1'b0}}};
            bf   = {sm, {GB{1'b0}}};
            if (diff >= WW) begin
                bv = {WW{1'b0}};
                st = 1'b1;
            end else begin
                bv = bf >> diff;
                st = |(bf & ~({WW{1'b1}} << diff));
            end
            // Jam the shifted-out bits into the LSB; guard bits keep rounding exact
            bv  = bv | {{(WW-1){1'b0}}, st};
            sum = (xs ^ ys) ? ({1'b0, av} - {1'b0, bv}) : ({1'b0, av} + {1'b0, bv});
            if (sum == {(WW+1){1'b0}}) begin
                res = ZERO;
            end else begin
                p = 0;
                for (int i = 0; i <= WW; i++) begin
                    if (sum[i]) begin
                        p = i;
                    end else begin
                        p = p;
                    end
                end
                nm   = sum << (WW - p);
                frac = nm[WW-1:0];
                rscl = int'(bscl) + p - (MW - 1) - GB;
                k    = rscl >>> ES;
                ev   = rscl[ES-1:0];
                if (k > N - 3) begin
                    body = {(N-1){1'b1}};
                end else if (k < -(N - 2)) begin
                    body = {{(N-2){1'b0}}, 1'b1};
                end else begin
                    tail = {ev, frac, {(L-T){1'b0}}};
                    if (k >= 0) begin
                        pat = ~({L{1'b1}} >> (k + 1));
                        rl  = k + 2;
                    end else begin
                        pat = {1'b1, {(L-1){1'b0}}} >> (-k);
                        rl  = 1 - k;
                    end
                    v    = pat | (tail >> rl);
                    body = v[L-1 -: N-1];
                    g    = v[L-N];
                    stk  = |v[L-N-1:0];
                    body = body + {{(N-2){1'b0}}, g & (stk | body[0])};
                end
                res = bs ? (~{1'b0, body} + {{(N-1){1'b0}}, 1'b1}) : {1'b0, body};
            end
        end
        return res;
    endfunction

    // Purely combinational sum of the two operands
    always_comb begin
        posit = add_core(a, b);
    end
endmodule

module posit_accum #(
    parameter int N     = 16,
    parameter int ES    = 3,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             busy,
    output logic             nar_seen
);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     acc_q;
    logic [N-1:0]     acc_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic             nar_q;
    logic             nar_d;
    logic [N-1:0]     sum_s;

    adder #(.N(N), .ES(ES)) u_adder (
        .a     (acc_q),
        .b     (in_data),
        .posit (sum_s)
    );

    // Frame control: start capture, per-beat accumulation, result hand-off
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        nar_d   = nar_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = {N{1'b0}};
                    nar_d = 1'b0;
                    if (len != {LEN_W{1'b0}}) begin
                        rem_d   = len;
                        state_d = S_ACCUM;
                    end else begin
                        rem_d   = {LEN_W{1'b0}};
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_s;
                    rem_d = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    nar_d = nar_q | (in_data == NAR);
                    if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= {N{1'b0}};
            rem_q   <= {LEN_W{1'b0}};
            nar_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            nar_q   <= nar_d;
        end
    end

    // Handshake flags come straight from the state register, never from inputs
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign nar_seen  = nar_q;
    assign out_data  = nar_q ? NAR : acc_q;
endmodule

// File: tb/tb_posit_accum.sv
module tb_posit_accum;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        nar_seen;

    int pass_cnt;
    int total_cnt;
    logic timeout_flag;

    posit_accum #(.N(16), .ES(3), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .nar_seen  (nar_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            timeout_flag = 1'b1;
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", out_data); else pass_cnt++;
        total_cnt++; if (nar_seen !== 1'b0) $display("FAIL reset_nar got %b want 0", nar_seen); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ones();
        timeout_flag = 1'b0;
        do_start(8'd4);
        total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL ones_accum_state got busy=%b in_ready=%b want 1 1", busy, in_ready); else pass_cnt++;
        send_beat(16'h4000);
        send_beat(16'h4000);
        send_beat(16'h4000);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL ones_early_valid got %b want 0", out_valid); else pass_cnt++;
        send_beat(16'h4000);
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL ones_timeout got %b want 0", timeout_flag); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL ones_out_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h4800) $display("FAIL ones_sum got %h want 4800", out_data); else pass_cnt++;
        total_cnt++; if (nar_seen !== 1'b0) $display("FAIL ones_nar got %b want 0", nar_seen); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL ones_done_in_ready got %b want 0", in_ready); else pass_cnt++;
        accept_out();
        total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL ones_after_accept got valid=%b busy=%b want 0 0", out_valid, busy); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h4800) $display("FAIL ones_acc_held got %h want 4800", out_data); else pass_cnt++;
    endtask

    task automatic test_gaps();
        timeout_flag = 1'b0;
        do_start(8'd2);
        send_beat(16'h4800);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL gaps_bubble%0d got valid=%b ready=%b want 0 1", i, out_valid, in_ready); else pass_cnt++;
        end
        send_beat(16'h5000);
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL gaps_timeout got %b want 0", timeout_flag); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL gaps_out_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h5100) $display("FAIL gaps_sum got %h want 5100", out_data); else pass_cnt++;
        accept_out();
    endtask

    task automatic test_nar();
        timeout_flag = 1'b0;
        do_start(8'd3);
        send_beat(16'h4400);
        send_beat(16'hC000);
        total_cnt++; if (nar_seen !== 1'b0) $display("FAIL nar_early got %b want 0", nar_seen); else pass_cnt++;
        send_beat(16'h8000);
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL nar_timeout got %b want 0", timeout_flag); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL nar_out_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h8000) $display("FAIL nar_sum got %h want 8000", out_data); else pass_cnt++;
        total_cnt++; if (nar_seen !== 1'b1) $display("FAIL nar_flag got %b want 1", nar_seen); else pass_cnt++;
        accept_out();
    endtask

    task automatic test_len0_hold();
        do_start(8'd0);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL len0_out_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0000) $display("FAIL len0_sum got %h want 0000", out_data); else pass_cnt++;
        total_cnt++; if (nar_seen !== 1'b0) $display("FAIL len0_nar_cleared got %b want 0", nar_seen); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0) ? 1'b1 : 1'b0;
            len   = 8'd3;
            @(posedge clk); #1;
            total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h0000 || in_ready !== 1'b0) $display("FAIL len0_hold%0d got valid=%b data=%h ready=%b want 1 0000 0", i, out_valid, out_data, in_ready); else pass_cnt++;
        end
        start = 1'b0;
        accept_out();
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL len0_release got busy=%b valid=%b want 0 0", busy, out_valid); else pass_cnt++;
    endtask

    task automatic test_cancel();
        timeout_flag = 1'b0;
        do_start(8'd2);
        send_beat(16'hCCF9);
        send_beat(16'h3307);
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL cancel_timeout got %b want 0", timeout_flag); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL cancel_out_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0000) $display("FAIL cancel_sum got %h want 0000", out_data); else pass_cnt++;
        accept_out();
    endtask

    task automatic test_reset_mid_frame();
        timeout_flag = 1'b0;
        do_start(8'd4);
        send_beat(16'h4000);
        send_beat(16'h4000);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst_flags got busy=%b ready=%b valid=%b want 0 0 0", busy, in_ready, out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0000 || nar_seen !== 1'b0) $display("FAIL midrst_data got data=%h nar=%b want 0000 0", out_data, nar_seen); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        do_start(8'd1);
        send_beat(16'h4000);
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL midrst_timeout got %b want 0", timeout_flag); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL midrst_out_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h4000) $display("FAIL midrst_sum got %h want 4000", out_data); else pass_cnt++;
        accept_out();
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        timeout_flag = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        len          = 8'd0;
        in_valid     = 1'b0;
        in_data      = 16'h0000;
        out_ready    = 1'b0;
        test_reset();
        test_ones();
        test_gaps();
        test_nar();
        test_len0_hold();
        test_cancel();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
